spinn_pkt_tx_2of7: RTL and testbench

- Downstream stage of the AER-to-SpiNNaker packet mapper.
- Consumes 72-bit SpiNNaker packets over a valid/ready handshake.
- Serializes each packet into 2-of-7 NRZ link symbols: nibbles first, then EOP.
- Paces every symbol on the asynchronous SpiNNaker ack toggle and flags a dead link on ack timeout.

---
 rtl/spinn_link_pkg.sv | 42 ++++
 rtl/spinn_sync_ff.sv | 23 ++
 rtl/spinn_pkt_tx_2of7.sv | 142 ++++++++++++++
 tb/tb_spinn_pkt_tx_2of7.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spinn_link_pkg.sv
// Shared definitions for the SpiNNaker 2-of-7 link transmitter and receiver.
package spinn_link_pkg;

    localparam int PKT_W            = 72;
    localparam int SHORT_NIBS       = 10;
    localparam int LONG_NIBS        = 18;
    localparam int PAYLOAD_FLAG_BIT = 1;

    localparam logic [6:0] EOP_SYM = 7'h60;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK
    } tx_state_t;

    // Every code has exactly two bits set, so one XOR toggles two wires.
    function automatic logic [6:0] sym_2of7(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0: code = 7'h11;
            4'h1: code = 7'h12;
            4'h2: code = 7'h14;
            4'h3: code = 7'h18;
            4'h4: code = 7'h21;
            4'h5: code = 7'h22;
            4'h6: code = 7'h24;
            4'h7: code = 7'h28;
            4'h8: code = 7'h41;
            4'h9: code = 7'h42;
            4'hA: code = 7'h44;
            4'hB: code = 7'h48;
            4'hC: code = 7'h03;
            4'hD: code = 7'h06;
            4'hE: code = 7'h0C;
            default: code = 7'h09;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/spinn_sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input, reset to 0.
module spinn_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spinn_pkt_tx_2of7.sv
// Serializes SpiNNaker packets into 2-of-7 NRZ symbols, paced by the link ack toggle,
// with an ack-timeout flag for a dead link.
module spinn_pkt_tx_2of7
    import spinn_link_pkg::*;
#(
    parameter int ACK_TIMEOUT = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] pkt_data,
    input  logic        pkt_vld,
    output logic        pkt_rdy,
    output logic [6:0]  lnk_data,
    input  logic        lnk_ack,
    output logic        busy,
    output logic        link_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    tx_state_t        state;
    tx_state_t        state_next;
    logic             ack_s;
    logic             ack_ref;
    logic             ack_edge;
    logic             accept;
    logic             eop_pending;
    logic [PKT_W-1:0] pkt_reg;
    logic [4:0]       nib_idx;
    logic [4:0]       last_idx;
    logic [3:0]       cur_nib;
    logic [CNT_W-1:0] ack_cnt;

    spinn_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d  (lnk_ack),
        .q  (ack_s)
    );

    assign ack_edge = ack_s ^ ack_ref;
    assign cur_nib  = pkt_reg[{nib_idx, 2'b00} +: 4];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pkt_rdy    = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                pkt_rdy = 1'b1;
                if (pkt_vld) begin
                    accept     = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                busy       = 1'b1;
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                busy = 1'b1;
                if (ack_edge) begin
                    state_next = eop_pending ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // ack_ref is left alone in SEND so an edge arriving there is still seen in WAIT_ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lnk_data    <= '0;
            link_err    <= 1'b0;
            ack_ref     <= 1'b0;
            eop_pending <= 1'b0;
            pkt_reg     <= '0;
            nib_idx     <= '0;
            last_idx    <= '0;
            ack_cnt     <= '0;
        end else begin
            case (state)
                ST_INIT, ST_IDLE: begin
                    ack_ref <= ack_s;
                    if (accept) begin
                        pkt_reg     <= pkt_data;
                        nib_idx     <= '0;
                        last_idx    <= pkt_data[PAYLOAD_FLAG_BIT] ? 5'(LONG_NIBS - 1)
                                                                  : 5'(SHORT_NIBS - 1);
                        eop_pending <= 1'b0;
                    end
                end
                ST_SEND: begin
                    lnk_data <= lnk_data ^ (eop_pending ? EOP_SYM : sym_2of7(cur_nib));
                    ack_cnt  <= '0;
                end
                ST_WAIT_ACK: begin
                    if (ack_edge) begin
                        ack_ref  <= ack_s;
                        link_err <= 1'b0;
                        if (eop_pending) begin
                            eop_pending <= 1'b0;
                        end else if (nib_idx == last_idx) begin
                            eop_pending <= 1'b1;
                        end else begin
                            nib_idx <= nib_idx + 5'd1;
                        end
                    end else begin
                        if (ack_cnt != CNT_MAX) begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                        if (ack_cnt >= CNT_LAST) begin
                            link_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spinn_pkt_tx_2of7.sv
// Self-checking bench for spinn_pkt_tx_2of7: a link responder echoes acks and a
// cycle-level model predicts symbols, their timing, pkt_rdy, busy and link_err.
module tb_spinn_pkt_tx_2of7;

    localparam int TO   = 16;
    localparam int SYNC = 2;
    localparam int BIG  = 32'h3fffffff;
    localparam logic [6:0] EOP = 7'h60;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy;
    logic [6:0]  lnk_data;
    logic        lnk_ack;
    logic        busy;
    logic        link_err;

    spinn_pkt_tx_2of7 #(
        .ACK_TIMEOUT(TO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pkt_data(pkt_data),
        .pkt_vld (pkt_vld),
        .pkt_rdy (pkt_rdy),
        .lnk_data(lnk_data),
        .lnk_ack (lnk_ack),
        .busy    (busy),
        .link_err(link_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] code_tab [16] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                                  7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09};

    logic [6:0]  exp_q[$];
    logic [6:0]  obs_q[$];
    logic [6:0]  obs_val_q[$];
    int          obs_cyc_q[$];
    int          acc_q[$];
    int          ack_q[$];
    logic [71:0] drv_q[$];

    int due       = BIG;
    int idle_from = BIG;
    int busy_from = BIG;
    int err_from  = BIG;
    int err_until = BIG;
    bit in_flight = 1'b0;
    bit in_reset  = 1'b1;
    logic [6:0] prev_lnk = '0;
    logic       prev_ack = 1'b0;

    int ack_delay    = 3;
    bit hold_ack     = 1'b0;
    bit spurious_req = 1'b0;

    task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Whole-packet symbol list: data nibbles LSB first, then EOP.
    function automatic void model_accept(input logic [71:0] p);
        int n;
        n = p[1] ? 18 : 10;
        for (int i = 0; i < n; i++) begin
            logic [71:0] sh;
            sh = p >> (4 * i);
            exp_q.push_back(code_tab[sh[3:0]]);
        end
        exp_q.push_back(EOP);
    endfunction

    always @(negedge clk) begin
        logic [6:0] delta;
        bit exp_rdy, exp_busy, exp_err;
        if (rst) begin
            check_output("rst_lnk_data", lnk_data, 0);
            check_output("rst_pkt_rdy", pkt_rdy, 0);
            check_output("rst_busy", busy, 0);
            check_output("rst_link_err", link_err, 0);
            exp_q.delete();
            in_flight = 1'b0;
            in_reset  = 1'b1;
            due = BIG; idle_from = BIG; busy_from = BIG; err_from = BIG; err_until = BIG;
            prev_lnk = '0;
            prev_ack = lnk_ack;
        end else begin
            if (in_reset) begin
                idle_from = cyc + 1;
                in_reset  = 1'b0;
            end
            exp_rdy  = (cyc >= idle_from);
            exp_busy = (cyc >= busy_from) && (cyc < idle_from);
            exp_err  = (cyc >= err_from) && (cyc <= err_until);
            check_output("pkt_rdy", pkt_rdy, exp_rdy);
            check_output("busy", busy, exp_busy);
            check_output("link_err", link_err, exp_err);
            if (lnk_data != prev_lnk) begin
                delta = lnk_data ^ prev_lnk;
                check_output("two_hot", $countones(delta), 2);
                if (exp_q.size() == 0) check_output("unexpected_symbol", delta, 0);
                else check_output("symbol", delta, exp_q.pop_front());
                check_output("symbol_time", cyc, due);
                due       = BIG;
                err_from  = cyc + TO;
                err_until = BIG;
                obs_q.push_back(delta);
                obs_val_q.push_back(lnk_data);
                obs_cyc_q.push_back(cyc);
            end else if (cyc >= due) begin
                check_output("symbol_missing", cyc, due);
                due = BIG;
            end
            if (lnk_ack != prev_ack) begin
                ack_q.push_back(cyc);
                if (in_flight) begin
                    err_until = cyc + SYNC;
                    if (exp_q.size() > 0) due = cyc + SYNC + 2;
                    else begin
                        idle_from = cyc + SYNC + 1;
                        in_flight = 1'b0;
                    end
                end
            end
            if (pkt_vld && pkt_rdy) begin
                model_accept(pkt_data);
                in_flight = 1'b1;
                due       = cyc + 2;
                busy_from = cyc + 1;
                idle_from = BIG;
                acc_q.push_back(cyc);
            end
            prev_lnk = lnk_data;
            prev_ack = lnk_ack;
        end
    end

    // Link-side responder: toggles the ack ack_delay cycles after each symbol.
    initial begin
        logic [6:0] seen;
        bit pending;
        int toggle_at;
        seen = '0; pending = 1'b0; toggle_at = 0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                seen = '0;
                pending = 1'b0;
            end else if (lnk_data != seen) begin
                seen = lnk_data;
                pending = 1'b1;
                toggle_at = cyc + ack_delay;
            end else if (pending && !hold_ack && cyc >= toggle_at) begin
                lnk_ack = ~lnk_ack;
                pending = 1'b0;
            end else if (!pending && spurious_req) begin
                lnk_ack = ~lnk_ack;
                spurious_req = 1'b0;
            end
        end
    end

    task automatic apply_stimulus();
        int waited = 0;
        @(posedge clk); #1;
        while (drv_q.size() > 0) begin
            pkt_data = drv_q[0];
            pkt_vld  = 1'b1;
            @(negedge clk);
            if (pkt_rdy) void'(drv_q.pop_front());
            else if (++waited > 3000) begin
                check_output("handshake_timeout", waited, 0);
                drv_q.delete();
            end
            @(posedge clk); #1;
        end
        pkt_vld = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((in_flight || !pkt_rdy) && n < 3000);
        check_output({name, "_done"}, n < 3000, 1);
        check_output({name, "_leftover"}, exp_q.size(), 0);
    endtask

    task automatic clear_logs();
        obs_q.delete(); obs_val_q.delete(); obs_cyc_q.delete(); acc_q.delete(); ack_q.delete();
    endtask

    initial begin
        logic [6:0]  pay_codes [8] = '{7'h09, 7'h0C, 7'h0C, 7'h48, 7'h06, 7'h44, 7'h0C, 7'h06};
        logic [95:0] r;
        logic [71:0] p1, p2;
        int n, sym3, rise;

        rst = 1'b1; pkt_vld = 1'b0; pkt_data = '0; lnk_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_lnk_data", lnk_data, 7'h00);
        check_output("reset_pkt_rdy", pkt_rdy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check_output("init_rdy_low", pkt_rdy, 0);
        @(negedge clk); check_output("idle_rdy_high", pkt_rdy, 1);

        // Short all-zero packet.
        clear_logs(); ack_delay = 3;
        drv_q.push_back(72'h0); apply_stimulus(); wait_done("zero");
        check_output("zero_count", obs_q.size(), 11);
        if (obs_q.size() == 11) begin
            check_output("zero_sym0", obs_q[0], 7'h11);
            check_output("zero_val0", obs_val_q[0], 7'h11);
            check_output("zero_val1", obs_val_q[1], 7'h00);
            check_output("zero_eop", obs_val_q[10], 7'h60);
        end
        check_output("zero_rdy_after", pkt_rdy, 1);

        // Short packet with ignored payload.
        clear_logs();
        drv_q.push_back({32'hCAFEBABE, 40'h00000000F0}); apply_stimulus(); wait_done("f0");
        check_output("f0_count", obs_q.size(), 11);
        if (obs_q.size() == 11) begin
            check_output("f0_sym0", obs_q[0], 7'h11);
            check_output("f0_sym1", obs_q[1], 7'h09);
        end

        // Long packet with DEADBEEF payload.
        clear_logs();
        drv_q.push_back({32'hDEADBEEF, 40'h0000000002}); apply_stimulus(); wait_done("long");
        check_output("long_count", obs_q.size(), 19);
        if (obs_q.size() == 19) begin
            check_output("long_sym0", obs_q[0], 7'h14);
            for (int i = 0; i < 8; i++) check_output("long_payload", obs_q[10 + i], pay_codes[i]);
        end

        // Ack withheld after the third symbol.
        clear_logs();
        drv_q.push_back(72'h0); apply_stimulus();
        n = 0;
        while (obs_q.size() < 3 && n < 500) begin @(negedge clk); #1; n++; end
        hold_ack = 1'b1;
        check_output("to_sym3_seen", obs_q.size(), 3);
        sym3 = (obs_cyc_q.size() >= 3) ? obs_cyc_q[2] : 0;
        rise = -1;
        repeat (25) begin
            @(negedge clk); #1;
            if (link_err && rise < 0) rise = cyc;
        end
        check_output("to_err_rise", rise - sym3, TO);
        check_output("to_err_held", link_err, 1);
        check_output("to_frozen", lnk_data, (obs_val_q.size() >= 3) ? obs_val_q[2] : 7'h7F);
        hold_ack = 1'b0;
        wait_done("timeout");
        check_output("to_err_cleared", link_err, 0);
        check_output("to_count", obs_q.size(), 11);

        // Reset in WAIT_ACK of the fifth symbol.
        clear_logs();
        drv_q.push_back({32'h12345678, 40'h0000000002}); apply_stimulus();
        n = 0;
        while (obs_q.size() < 5 && n < 500) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_output("rst_async_lnk", lnk_data, 7'h00);
        check_output("rst_async_rdy", pkt_rdy, 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check_output("rst_init_rdy", pkt_rdy, 0);
        @(negedge clk); check_output("rst_idle_rdy", pkt_rdy, 1);
        repeat (8) @(negedge clk);

        // Back-to-back: short then long with pkt_vld held.
        clear_logs(); ack_delay = 2;
        r = {$urandom, $urandom, $urandom}; p1 = r[71:0]; p1[1] = 1'b0;
        r = {$urandom, $urandom, $urandom}; p2 = r[71:0]; p2[1] = 1'b1;
        drv_q.push_back(p1); drv_q.push_back(p2); apply_stimulus(); wait_done("b2b");
        check_output("b2b_count", obs_q.size(), 30);
        if (acc_q.size() == 2 && ack_q.size() >= 11)
            check_output("b2b_gap", acc_q[1] - ack_q[10], SYNC + 1);
        else check_output("b2b_logs", acc_q.size(), 2);

        // Randomized traffic, delays straddling the timeout, spurious idle acks.
        for (int t = 0; t < 25; t++) begin
            ack_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 15) : $urandom_range(1, 6);
            if ($urandom_range(0, 2) == 0) begin
                spurious_req = 1'b1;
                repeat (8) @(negedge clk);
            end
            r = {$urandom, $urandom, $urandom}; drv_q.push_back(r[71:0]);
            if ($urandom_range(0, 3) == 0) begin
                r = {$urandom, $urandom, $urandom}; drv_q.push_back(r[71:0]);
            end
            apply_stimulus();
            wait_done("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "[TB] watchdog");
    end

endmodule
